mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the execute stage. Successor to the fixed-latency MultModule.
- Holds the architectural HI/LO registers.
- Adds configurable operand width and per-operation latency, cancel-on-exception, defined divide corner cases, and optional multiply-accumulate.
- Execute-stage operand forwarding feeds a/b. The hazard unit stalls dependent instructions using busy.

Parameters:
- WIDTH, 32: operand width and HI/LO width.
- MULT_LAT, 5: cycles busy for multiply-class ops; legal range ≥1.
- DIV_LAT, 10: cycles busy for divide-class ops; legal range ≥1.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; asynchronous, active-high.
- start  input  1  op valid this cycle.
- op  input  4  operation code (md_pkg).
- a  input  WIDTH  rs operand, already forwarded.
- b  input  WIDTH  rt operand, already forwarded.
- cancel  input  1  exception/flush; aborts an in-flight op.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO were just updated by a multi-cycle op.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: asynchronous, active-high. Forces hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, including mid-operation.
- State machine: IDLE, RUN.
- In IDLE with start=1 and op in {MULT, MULTU, DIV, DIVU}:
  - Latch the computed result into internal res_hi/res_lo.
  - Load counter with the op's latency; go to RUN.
  - busy=1 for exactly LAT cycles: t+1 .. t+LAT.
- In RUN: counter decrements each cycle. On the edge leaving the last busy cycle, hi/lo are written and state goes to IDLE. In cycle t+LAT+1: done=1, busy=0, new hi/lo visible.
- MTHI/MTLO in IDLE: write a into hi or lo at the next edge. Single cycle; busy stays 0; no done.
- start while RUN: ignored, and hi/lo are untouched. The hazard unit guarantees this never occurs; the bench flags it.
- op=MD_NONE or an undefined code: no effect.
- Arithmetic:
  - MULT: signed full-width product {hi,lo}, 2*WIDTH bits.
  - MULTU: unsigned full-width product {hi,lo}.
  - DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
  - DIVU: unsigned quotient/remainder.
- Divide corner cases:
  - Divide by zero: lo = all ones, hi = a (both DIV and DIVU).
  - DIV with a = most-negative value and b = -1: lo = most-negative value, hi = 0.
- Cancel:
  - cancel=1 in RUN: next edge goes to IDLE, busy=0, hi/lo keep their pre-op values, no done.
  - cancel=1 together with start in IDLE: start is dropped, including MTHI/MTLO.
  - cancel in IDLE without start: no effect.
- done is never asserted in the same cycle as busy.

Optional Feature:
- Macro MULT_DIV_MADD_EN.
- Defined: ops MADD, MADDU, MSUB, MSUBU are accepted. Each adds the signed/unsigned product to {hi,lo} (MADD/MADDU) or subtracts it (MSUB/MSUBU), modulo 2^(2*WIDTH). The accumulate uses the {hi,lo} value at acceptance. Latency MULT_LAT; cancel leaves {hi,lo} unchanged.
- Undefined: these codes behave as MD_NONE.

Decomposition:
- md_pkg holds:
  - op localparams: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - state encodings IDLE/RUN.
  - helper constant for the most-negative value.
- One sub-module, md_compute: combinational WIDTH-parametrised result generation covering products, quotient/remainder, corner-case overrides and the accumulate path. The top holds the FSM, counter and HI/LO.

Test Plan:
- MULT, a=0xFFFFFFFE, b=3, start at t → busy t+1..t+5; in t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for one cycle.
- DIVU, a=100, b=7 → busy t+1..t+10; in t+11 lo=14, hi=2, done=1.
- DIV, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU, a=5, b=0 → lo=0xFFFFFFFF, hi=5.
- MTHI a=0x1234 in IDLE → hi=0x1234 next cycle, busy never 1. Then MULT 2*3, and a second start(MULT 4*4) on busy cycle 2 → final lo=6, hi=0.
- Preload hi=1, lo=2; DIV 9/2; cancel on busy cycle 3 → busy=0 next cycle, hi=1, lo=2, done never asserted.
- reset asserted mid-MULT, between clock edges → hi, lo, busy, done go 0 immediately. After release, MULTU 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.

Source files
------------

// File: rtl/md_pkg.sv
// Shared op codes, FSM states and helpers for the multiply/divide unit.
// Optional multiply-accumulate ops are enabled by MULT_DIV_MADD_EN.
package md_pkg;

  localparam logic [3:0] MD_NONE = 4'd0;
  localparam logic [3:0] MULT    = 4'd1;
  localparam logic [3:0] MULTU   = 4'd2;
  localparam logic [3:0] DIV     = 4'd3;
  localparam logic [3:0] DIVU    = 4'd4;
  localparam logic [3:0] MTHI    = 4'd5;
  localparam logic [3:0] MTLO    = 4'd6;
  localparam logic [3:0] MADD    = 4'd7;
  localparam logic [3:0] MADDU   = 4'd8;
  localparam logic [3:0] MSUB    = 4'd9;
  localparam logic [3:0] MSUBU   = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Most-negative two's complement value of width w (w <= 128).
  function automatic logic [127:0] md_most_neg(input int w);
    md_most_neg = 128'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational result generation: products, quotient/remainder,
// divide corner cases and, with MULT_DIV_MADD_EN, the accumulate path.
module md_compute
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULT_DIV_MADD_EN
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
`endif
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [WIDTH-1:0] MOST_NEG =
    WIDTH'(md_most_neg(WIDTH));
  localparam logic [WIDTH-1:0] ONE =
    WIDTH'(1);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               b_zero;
  logic               ovf;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   uq, ur;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   mq, mr;
  logic [WIDTH-1:0]   sq, sr;

  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} *
                  {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} *
                  {{WIDTH{1'b0}}, b};

  assign b_zero = (b == '0);
  assign ovf    = (a == MOST_NEG) && (b == '1);
  // Divisor forced to 1 on zero so the dividers never see /0.
  assign b_safe = b_zero ? ONE : b;

  assign uq = a / b_safe;
  assign ur = a % b_safe;

  // Signed divide on magnitudes, then restore signs.
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b_zero ? ONE
               : (b[WIDTH-1] ? -b : b);
  assign mq = abs_a / abs_b;
  assign mr = abs_a % abs_b;
  assign sq = (a[WIDTH-1] ^ b[WIDTH-1]) ? -mq : mq;
  assign sr = a[WIDTH-1] ? -mr : mr;

  // Select the result pair for the requested op.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MULT:  {res_hi, res_lo} = prod_s;
      MULTU: {res_hi, res_lo} = prod_u;
      DIV: begin
        if (b_zero) begin
          res_hi = a;
          res_lo = '1;
        end else if (ovf) begin
          res_hi = '0;
          res_lo = MOST_NEG;
        end else begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      DIVU: begin
        if (b_zero) begin
          res_hi = a;
          res_lo = '1;
        end else begin
          res_hi = ur;
          res_lo = uq;
        end
      end
`ifdef MULT_DIV_MADD_EN
      MADD:  {res_hi, res_lo} = {hi_in, lo_in} + prod_s;
      MADDU: {res_hi, res_lo} = {hi_in, lo_in} + prod_u;
      MSUB:  {res_hi, res_lo} = {hi_in, lo_in} - prod_s;
      MSUBU: {res_hi, res_lo} = {hi_in, lo_in} - prod_u;
`endif
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO for the execute stage.
// Define MULT_DIV_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT =
    (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] c_hi, c_lo;
  logic             is_mult, is_div;

  md_compute #(
    .WIDTH (WIDTH)
  ) u_compute (
    .op     (op),
    .a      (a),
    .b      (b),
`ifdef MULT_DIV_MADD_EN
    .hi_in  (hi_q),
    .lo_in  (lo_q),
`endif
    .res_hi (c_hi),
    .res_lo (c_lo)
  );

  // Classify the incoming op by latency class.
  always_comb begin
    is_mult = 1'b0;
    is_div  = 1'b0;
    case (op)
      MULT, MULTU: is_mult = 1'b1;
`ifdef MULT_DIV_MADD_EN
      MADD, MADDU,
      MSUB, MSUBU: is_mult = 1'b1;
`endif
      DIV, DIVU:   is_div  = 1'b1;
      default: begin
        is_mult = 1'b0;
        is_div  = 1'b0;
      end
    endcase
  end

  // Next-state: accept in IDLE, count down in RUN, commit or cancel.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          if (is_mult || is_div) begin
            res_hi_d = c_hi;
            res_lo_d = c_lo;
            cnt_d    = is_div ? DIV_CNT : MULT_CNT;
            state_d  = RUN;
          end else if (op == MTHI) begin
            hi_d = a;
          end else if (op == MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ONE) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random
// model-checked ops, and hand sequences for cancel/reset/overlap.
module tb_mult_div_unit;
  import md_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[10];

  mult_div_unit #(
    .WIDTH    (32),
    .MULT_LAT (ML),
    .DIV_LAT  (DL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint q, r;
    logic [63:0] ux, uy;
    model = '0;
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (o == MULT) begin
      q = longint'($signed(x)) * longint'($signed(y));
      model = q;
    end else if (o == MULTU) begin
      model = ux * uy;
    end else if (y == 32'd0) begin
      model = {x, 32'hFFFF_FFFF};
    end else if (o == DIV) begin
      q = longint'($signed(x)) / longint'($signed(y));
      r = longint'($signed(x)) % longint'($signed(y));
      model = {r[31:0], q[31:0]};
    end else begin
      model = {x % y, x / y};
    end
  endfunction

  task automatic finish_op(input string nm);
    logic [63:0] e;
    chk({nm, " done"}, {63'd0, done}, 64'd1);
    chk({nm, " busy_low"}, {63'd0, busy}, 64'd0);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s scoreboard: got empty want entry", nm);
    end else begin
      e = sb_q.pop_front();
      chk({nm, " hilo"}, {hi, lo}, e);
    end
    tick();
    chk({nm, " done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  task automatic run_op(input logic [3:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [63:0] exp,
                        input int lat,
                        input string nm);
    int n;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    sb_q.push_back(exp);
    tick();
    start = 1'b0;
    op = MD_NONE;
    n = 0;
    while (busy && n < 100) begin
      chk({nm, " done_in_busy"}, {63'd0, done}, 64'd0);
      n++;
      tick();
    end
    chk({nm, " busy_cycles"}, 64'(n), 64'(lat));
    finish_op(nm);
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] v);
    op = o;
    a = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    op = MD_NONE;
    chk("mt busy", {63'd0, busy}, 64'd0);
    chk("mt done", {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    int n;
    int seen;

    tbl[0] = '{MULT,  32'hFFFF_FFFE, 32'd3,
               64'hFFFF_FFFF_FFFF_FFFA};
    tbl[1] = '{DIVU,  32'd100, 32'd7, {32'd2, 32'd14}};
    tbl[2] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF,
               {32'd0, 32'h8000_0000}};
    tbl[3] = '{DIVU,  32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}};
    tbl[4] = '{DIV,   32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}};
    tbl[5] = '{DIV,   32'hFFFF_FFF9, 32'd2,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    tbl[6] = '{DIV,   32'd7, 32'hFFFF_FFFE,
               {32'd1, 32'hFFFF_FFFD}};
    tbl[7] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001};
    tbl[8] = '{MULT,  32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000};
    tbl[9] = '{MULTU, 32'h1234_5678, 32'h10,
               64'h0000_0001_2345_6780};

    reset = 1'b1;
    start = 1'b0;
    op = MD_NONE;
    a = '0;
    b = '0;
    cancel = 1'b0;
    tick();
    tick();
    chk("rst hi", {32'd0, hi}, 64'd0);
    chk("rst lo", {32'd0, lo}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp,
             (tbl[i].op == DIV || tbl[i].op == DIVU) ? DL : ML,
             $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      ro = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb),
             (ro == DIV || ro == DIVU) ? DL : ML,
             $sformatf("rnd%0d", i));
    end

    // MTHI, then MULT with a stray start on busy cycle 2.
    mt(MTLO, 32'h0);
    mt(MTHI, 32'h1234);
    chk("mthi hi", {32'd0, hi}, 64'h1234);
    op = MULT;
    a = 32'd2;
    b = 32'd3;
    start = 1'b1;
    sb_q.push_back(64'd6);
    tick();
    start = 1'b0;
    chk("ovl busy1", {63'd0, busy}, 64'd1);
    tick();
    chk("ovl busy2", {63'd0, busy}, 64'd1);
    $display("note: start issued while busy (design must ignore)");
    op = MULT;
    a = 32'd4;
    b = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    op = MD_NONE;
    chk("ovl hi_held", {32'd0, hi}, 64'h1234);
    n = 2;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk("ovl busy_cycles", 64'(n), 64'(ML));
    finish_op("ovl");

    // Cancel a DIV on busy cycle 3.
    mt(MTHI, 32'd1);
    mt(MTLO, 32'd2);
    op = DIV;
    a = 32'd9;
    b = 32'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    op = MD_NONE;
    tick();
    tick();
    chk("cxl busy3", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cxl busy", {63'd0, busy}, 64'd0);
    chk("cxl hi", {32'd0, hi}, 64'd1);
    chk("cxl lo", {32'd0, lo}, 64'd2);
    seen = 0;
    for (int i = 0; i < DL + 2; i++) begin
      if (done) seen++;
      tick();
    end
    chk("cxl no_done", 64'(seen), 64'd0);

    // Cancel with start in IDLE drops MTHI.
    op = MTHI;
    a = 32'h55;
    start = 1'b1;
    cancel = 1'b1;
    tick();
    start = 1'b0;
    cancel = 1'b0;
    op = MD_NONE;
    chk("cxl_idle hi", {32'd0, hi}, 64'd1);
    chk("cxl_idle busy", {63'd0, busy}, 64'd0);

    // Undefined op has no effect.
    mt(4'd15, 32'hDEAD);
    chk("undef hilo", {hi, lo}, {32'd1, 32'd2});

`ifdef MULT_DIV_MADD_EN
    run_op(MADD, 32'd2, 32'd3, {32'd1, 32'd8}, ML, "madd");
    run_op(MSUBU, 32'd1, 32'd9, {32'd0, 32'hFFFF_FFFF},
           ML, "msubu");
`else
    mt(MADD, 32'd2);
    chk("madd_off hilo", {hi, lo}, {32'd1, 32'd2});
`endif

    // Async reset in the middle of a MULT.
    mt(MTHI, 32'hA5A5);
    op = MULT;
    a = 32'd7;
    b = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    op = MD_NONE;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst hi", {32'd0, hi}, 64'd0);
    chk("arst lo", {32'd0, lo}, 64'd0);
    chk("arst busy", {63'd0, busy}, 64'd0);
    chk("arst done", {63'd0, done}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, ML, "post_rst");

    chk("sb empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
